// File: rtl/izh_neuron_array_if.sv
// Stimulus/config/spike bus of the time-multiplexed Izhikevich neuron array.
interface izh_neuron_array_if #(
  parameter int unsigned IDX_W = 2,
  parameter int unsigned I_W   = 5
);
  logic             tick;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [2:0]       cfg_mode;
  logic [IDX_W-1:0] cur_addr;
  logic [I_W-1:0]   cur_data;
  logic             busy;
  logic             done;
  logic             spike_valid;
  logic [IDX_W-1:0] spike_idx;
  logic [7:0]       v_out;
  logic [7:0]       u_out;

  modport master (
    output tick, cfg_we, cfg_idx, cfg_mode, cur_data,
    input  cur_addr, busy, done, spike_valid, spike_idx, v_out, u_out
  );

  modport slave (
    input  tick, cfg_we, cfg_idx, cfg_mode, cur_data,
    output cur_addr, busy, done, spike_valid, spike_idx, v_out, u_out
  );
endinterface

// File: rtl/izh_neuron_array.sv
// Array of Izhikevich neurons sharing one saturating fixed-point Euler datapath.
module izh_neuron_array #(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned WIDTH     = 22,
  parameter int unsigned FRAC      = 18,
  parameter int unsigned I_W       = 5
) (
  input logic               clk,
  input logic               rst,
  izh_neuron_array_if.slave bus
);
  localparam int unsigned IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int unsigned W2    = 2 * WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] CALC  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [2:0] M_RS  = 3'd0;
  localparam logic [2:0] M_IB  = 3'd1;
  localparam logic [2:0] M_CH  = 3'd2;
  localparam logic [2:0] M_FS  = 3'd3;
  localparam logic [2:0] M_TC  = 3'd4;
  localparam logic [2:0] M_TCI = 3'd5;
  localparam logic [2:0] M_RZ  = 3'd6;

  // Round-half-away-from-zero conversion of a real constant to fixed point.
  function automatic logic signed [WIDTH-1:0] q(input real x);
    real r;
    r = x * (2.0 ** FRAC);
    if (r >= 0.0) q = WIDTH'($rtoi(r + 0.5));
    else          q = WIDTH'(-$rtoi(0.5 - r));
  endfunction

  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] S_MIN = ~S_MAX;
  localparam logic signed [W2-1:0]    P_MAX = W2'({1'b0, {(WIDTH-1){1'b1}}});
  localparam logic signed [W2-1:0]    P_MIN = ~P_MAX;

  localparam logic signed [WIDTH-1:0] K2     = q(4.0);
  localparam logic signed [WIDTH-1:0] K1     = q(5.0);
  localparam logic signed [WIDTH-1:0] K0     = q(1.3947);
  localparam logic signed [WIDTH-1:0] KU     = q(-0.3157);
  localparam logic signed [WIDTH-1:0] KC     = q(0.0166);
  localparam logic signed [WIDTH-1:0] TAU    = q(0.2);
  localparam logic signed [WIDTH-1:0] VTH    = q(0.30);
  localparam logic signed [WIDTH-1:0] BIAS   = q(0.0066);
  localparam logic signed [WIDTH-1:0] A_FAST = q(0.10);
  localparam logic signed [WIDTH-1:0] A_SLOW = q(0.02);
  localparam logic signed [WIDTH-1:0] B_LO   = q(0.6333);
  localparam logic signed [WIDTH-1:0] B_HI   = q(0.7917);
  localparam logic signed [WIDTH-1:0] C_IB   = q(-0.55);
  localparam logic signed [WIDTH-1:0] C_CH   = q(-0.50);
  localparam logic signed [WIDTH-1:0] C_TCI  = q(-0.87);
  localparam logic signed [WIDTH-1:0] C_DEF  = q(-0.65);
  localparam logic signed [WIDTH-1:0] D_RS   = q(0.2528);
  localparam logic signed [WIDTH-1:0] D_IB   = q(0.1264);
  localparam logic signed [WIDTH-1:0] D_TC   = q(0.00158);
  localparam logic signed [WIDTH-1:0] D_DEF  = q(0.0632);
  localparam logic signed [WIDTH-1:0] U_RLO  = q(-0.13);
  localparam logic signed [WIDTH-1:0] U_RHI  = q(-0.1625);

  // Full-width product, arithmetic rescale, saturate back to WIDTH.
  function automatic logic signed [WIDTH-1:0] mul(input logic signed [WIDTH-1:0] x,
                                                  input logic signed [WIDTH-1:0] y);
    logic signed [W2-1:0] p;
    p = (W2'(x) * W2'(y)) >>> FRAC;
    if (p > P_MAX)      mul = S_MAX;
    else if (p < P_MIN) mul = S_MIN;
    else                mul = p[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] add(input logic signed [WIDTH-1:0] x,
                                                  input logic signed [WIDTH-1:0] y);
    logic signed [WIDTH:0] s;
    s = (WIDTH+1)'(x) + (WIDTH+1)'(y);
    if (s[WIDTH] != s[WIDTH-1]) add = s[WIDTH] ? S_MIN : S_MAX;
    else                        add = s[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] sub(input logic signed [WIDTH-1:0] x,
                                                  input logic signed [WIDTH-1:0] y);
    logic signed [WIDTH:0] s;
    s = (WIDTH+1)'(x) - (WIDTH+1)'(y);
    if (s[WIDTH] != s[WIDTH-1]) sub = s[WIDTH] ? S_MIN : S_MAX;
    else                        sub = s[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] u_rst(input logic [2:0] m);
    u_rst = (m <= M_FS) ? U_RLO : U_RHI;
  endfunction

  function automatic logic [7:0] pk(input logic signed [WIDTH-1:0] x);
    pk = {x[WIDTH-1], x[FRAC-1:FRAC-7]};
  endfunction

  logic [2:0]              mode_mem [N_NEURONS];
  logic signed [WIDTH-1:0] v_mem    [N_NEURONS];
  logic signed [WIDTH-1:0] u_mem    [N_NEURONS];

  logic [1:0]              state, state_nx;
  logic [IDX_W-1:0]        n;
  logic                    last;
  logic [2:0]              m_n;
  logic signed [WIDTH-1:0] v_r, u_r, a_r, b_r, c_r, d_r;
  logic signed [WIDTH-1:0] a_c, b_c, c_c, d_c;
  logic signed [WIDTH-1:0] iin, s, dv, du, vn, un, ud;
  logic                    fire;

  assign last = (n == IDX_W'(N_NEURONS - 1));
  assign m_n  = mode_mem[n];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; ticks outside IDLE are dropped.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.tick) state_nx = LOAD;
      LOAD:    state_nx = CALC;
      CALC:    state_nx = WRITE;
      WRITE:   state_nx = last ? IDLE : LOAD;
      default: state_nx = IDLE;
    endcase
  end

  // Mode table decode for the neuron being loaded.
  always_comb begin
    a_c = A_SLOW;
    b_c = B_LO;
    c_c = C_DEF;
    d_c = D_DEF;
    if (m_n == M_FS || m_n == M_RZ) a_c = A_FAST;
    if (m_n > M_FS) b_c = B_HI;
    case (m_n)
      M_IB:    c_c = C_IB;
      M_CH:    c_c = C_CH;
      M_TCI:   c_c = C_TCI;
      default: ;
    endcase
    case (m_n)
      M_RS:        d_c = D_RS;
      M_IB:        d_c = D_IB;
      M_TC, M_TCI: d_c = D_TC;
      default:     ;
    endcase
  end

  // One Euler step, evaluated left to right with saturation after every operation.
  always_comb begin
    iin  = add($signed(WIDTH'(bus.cur_data) << (FRAC - I_W)), BIAS);
    s    = mul(mul(K2, v_r), v_r);
    s    = add(s, mul(K1, v_r));
    s    = add(s, K0);
    s    = add(s, mul(KU, u_r));
    s    = add(s, iin);
    dv   = mul(TAU, s);
    du   = mul(mul(TAU, a_r), sub(mul(b_r, v_r), add(u_r, KC)));
    vn   = add(v_r, dv);
    un   = add(u_r, du);
    ud   = add(u_r, d_r);
    fire = (vn >= VTH);
  end

  // Datapath, neuron state and registered outputs; results land on entry to WRITE
  // so the write-cycle outputs coincide with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        mode_mem[i] <= M_RS;
        v_mem[i]    <= C_DEF;
        u_mem[i]    <= U_RLO;
      end
      n               <= '0;
      v_r             <= '0;
      u_r             <= '0;
      a_r             <= '0;
      b_r             <= '0;
      c_r             <= '0;
      d_r             <= '0;
      bus.cur_addr    <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.spike_valid <= 1'b0;
      bus.spike_idx   <= '0;
      bus.v_out       <= '0;
      bus.u_out       <= '0;
    end else begin
      bus.done        <= 1'b0;
      bus.spike_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_we && (32'(bus.cfg_idx) < N_NEURONS)) begin
            mode_mem[bus.cfg_idx] <= bus.cfg_mode;
            v_mem[bus.cfg_idx]    <= C_DEF;
            u_mem[bus.cfg_idx]    <= u_rst(bus.cfg_mode);
          end
          if (bus.tick) begin
            bus.busy     <= 1'b1;
            n            <= '0;
            bus.cur_addr <= '0;
          end
        end
        LOAD: begin
          v_r <= v_mem[n];
          u_r <= u_mem[n];
          a_r <= a_c;
          b_r <= b_c;
          c_r <= c_c;
          d_r <= d_c;
        end
        CALC: begin
          if (fire) begin
            v_mem[n]        <= c_r;
            u_mem[n]        <= ud;
            bus.spike_valid <= 1'b1;
            bus.spike_idx   <= n;
            bus.v_out       <= pk(c_r);
            bus.u_out       <= pk(ud);
          end else begin
            v_mem[n]  <= vn;
            u_mem[n]  <= un;
            bus.v_out <= pk(vn);
            bus.u_out <= pk(un);
          end
          if (last) bus.done <= 1'b1;
        end
        WRITE: begin
          if (last) begin
            bus.busy <= 1'b0;
          end else begin
            n            <= n + IDX_W'(1);
            bus.cur_addr <= n + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_izh_neuron_array.sv
// Scoreboard bench for izh_neuron_array: a behavioural model predicts each neuron write.
module tb_izh_neuron_array;
  localparam int unsigned N     = 4;
  localparam int unsigned WIDTH = 22;
  localparam int unsigned FRAC  = 18;
  localparam int unsigned I_W   = 5;
  localparam int unsigned IDX_W = 2;

  localparam longint SMAX  = 2097151;
  localparam longint SMIN  = -2097152;
  localparam longint K2    = 1048576;
  localparam longint K1    = 1310720;
  localparam longint K0    = 365612;
  localparam longint KU    = -82759;
  localparam longint KC    = 4352;
  localparam longint TAU   = 52429;
  localparam longint VTH   = 78643;
  localparam longint BIAS  = 1730;
  localparam longint V_RST = -170394;
  localparam longint U_LO  = -34079;
  localparam longint U_HI  = -42598;

  typedef struct {
    int         idx;
    bit         spk;
    logic [7:0] v;
    logic [7:0] u;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  izh_neuron_array_if #(.IDX_W(IDX_W), .I_W(I_W)) bus ();

  izh_neuron_array #(.N_NEURONS(N), .WIDTH(WIDTH), .FRAC(FRAC), .I_W(I_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [I_W-1:0] cur_mem [N];
  always @(posedge clk) bus.cur_data <= cur_mem[bus.cur_addr];

  longint     mv [N];
  longint     mu [N];
  int         mmode [N];
  exp_t       sbq [$];
  logic [N-1:0] spk_mask;
  logic [7:0] spk_v [N];
  int         other_spk;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint x);
    return (x > SMAX) ? SMAX : ((x < SMIN) ? SMIN : x);
  endfunction

  function automatic longint mul(input longint a, input longint b);
    return sat((a * b) >>> FRAC);
  endfunction

  function automatic logic [7:0] pack8(input longint x);
    logic [63:0] w;
    w = x;
    return {w[21], w[17:11]};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mmode[i] = 0;
      mv[i]    = V_RST;
      mu[i]    = U_LO;
    end
  endfunction

  function automatic exp_t model_step(input int k);
    longint v, u, a, b, c, d, iin, s, dv, du, vn, un;
    int m;
    exp_t e;
    m = mmode[k];
    v = mv[k];
    u = mu[k];
    a = (m == 3 || m == 6) ? 26214 : 5243;
    b = (m < 4) ? 166016 : 207539;
    case (m)
      1:       c = -144179;
      2:       c = -131072;
      5:       c = -228065;
      default: c = V_RST;
    endcase
    case (m)
      0:       d = 66270;
      1:       d = 33135;
      4, 5:    d = 414;
      default: d = 16568;
    endcase
    iin = sat((longint'(cur_mem[k]) << (FRAC - I_W)) + BIAS);
    s  = mul(mul(K2, v), v);
    s  = sat(s + mul(K1, v));
    s  = sat(s + K0);
    s  = sat(s + mul(KU, u));
    s  = sat(s + iin);
    dv = mul(TAU, s);
    du = mul(mul(TAU, a), sat(mul(b, v) - sat(u + KC)));
    vn = sat(v + dv);
    un = sat(u + du);
    e.idx = k;
    e.spk = (vn >= VTH);
    if (e.spk) begin
      mv[k] = c;
      mu[k] = sat(u + d);
    end else begin
      mv[k] = vn;
      mu[k] = un;
    end
    e.v = pack8(mv[k]);
    e.u = pack8(mu[k]);
    return e;
  endfunction

  task automatic cfg(input int idx, input int m);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = IDX_W'(idx);
    bus.cfg_mode = 3'(m);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    mmode[idx] = m;
    mv[idx]    = V_RST;
    mu[idx]    = (m < 4) ? U_LO : U_HI;
  endtask

  // One full sweep; optional mid-sweep tick and cfg write must have no effect.
  task automatic run_sweep(input bit mid_tick, input bit mid_cfg);
    exp_t e;
    int stray;
    stray = 0;
    spk_mask = '0;
    @(negedge clk);
    bus.tick = 1'b1;
    for (int k = 0; k < N; k++) sbq.push_back(model_step(k));
    for (int c = 1; c <= 3 * N + 6; c++) begin
      @(negedge clk);
      if (c == 1) check("busy_rise", bus.busy, 1);
      if (c <= 3 * N && c % 3 == 0) begin
        if (sbq.size() == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("v_out", bus.v_out, e.v);
          check("u_out", bus.u_out, e.u);
          check("spike_valid", bus.spike_valid, e.spk);
          if (e.spk) begin
            check("spike_idx", bus.spike_idx, e.idx);
            spk_mask[e.idx] = 1'b1;
            spk_v[e.idx]    = bus.v_out;
          end
          check("done", bus.done, (c == 3 * N));
          if (c == 3 * N) check("busy_at_done", bus.busy, 1);
        end
        if (bus.spike_valid && bus.spike_idx != 0) other_spk++;
      end else begin
        if (bus.spike_valid || bus.done) stray++;
        if (c > 3 * N && bus.busy) stray++;
      end
      bus.tick   = mid_tick && (c == 5);
      bus.cfg_we = mid_cfg && (c == 4);
      if (mid_cfg && c == 4) begin
        bus.cfg_idx  = 2'd1;
        bus.cfg_mode = 3'd7;
      end
    end
    check("stray_pulse", stray, 0);
  endtask

  initial begin
    longint pre;
    int stray;
    rst          = 1'b1;
    bus.tick     = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_idx  = '0;
    bus.cfg_mode = '0;
    other_spk    = 0;
    for (int i = 0; i < N; i++) cur_mem[i] = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_spike_valid", bus.spike_valid, 0);
    check("rst_spike_idx", bus.spike_idx, 0);
    check("rst_v_out", bus.v_out, 0);
    check("rst_u_out", bus.u_out, 0);
    check("rst_cur_addr", bus.cur_addr, 0);

    // basic sweep, no current
    run_sweep(0, 0);
    check("t1_no_spike", spk_mask, 0);

    // strong current on neuron 0 only
    cur_mem[0] = 5'd31;
    other_spk  = 0;
    spk_mask   = '0;
    pre        = 0;
    for (int t = 0; t < 100 && !spk_mask[0]; t++) begin
      pre = mu[0];
      run_sweep(0, 0);
    end
    check("t2_spiked", spk_mask[0], 1);
    check("t2_v_reset", longint'(dut.v_mem[0]), V_RST);
    check("t2_u_step", longint'(dut.u_mem[0]), sat(pre + 66270));
    check("t2_silent", other_spk, 0);

    // chattering neuron 1
    cur_mem[0] = '0;
    cur_mem[1] = 5'd31;
    cfg(1, 2);
    spk_mask = '0;
    for (int t = 0; t < 100 && !spk_mask[1]; t++) begin
      pre = mu[1];
      run_sweep(0, 0);
    end
    check("t3_spiked", spk_mask[1], 1);
    check("t3_v_out", spk_v[1], 8'hC0);
    check("t3_u_step", longint'(dut.u_mem[1]), sat(pre + 16568));

    // cfg and tick while busy are ignored
    run_sweep(1, 1);
    for (int t = 0; t < 100 && !spk_mask[1]; t++) run_sweep(0, 0);
    check("t4_spiked", spk_mask[1], 1);
    check("t4_mode_kept", spk_v[1], 8'hC0);

    // reset during CALC of neuron 2
    cur_mem[1] = '0;
    stray = 0;
    @(negedge clk);
    bus.tick = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.tick = 1'b0;
      if (c >= 9 && (bus.spike_valid || bus.done)) stray++;
      if (c == 9) begin
        check("t5_busy", bus.busy, 0);
        check("t5_v_out", bus.v_out, 0);
        check("t5_cur_addr", bus.cur_addr, 0);
      end
      if (c == 8) rst = 1'b1;
      if (c == 9) rst = 1'b0;
    end
    check("t5_no_pulse", stray, 0);
    model_reset();
    run_sweep(0, 0);

    // saturation from a backdoor V = max
    @(negedge clk);
    dut.v_mem[0] <= 22'sh1FFFFF;
    mv[0] = SMAX;
    run_sweep(0, 0);
    check("t6_spiked", spk_mask[0], 1);
    check("t6_v_reset", spk_v[0], pack8(V_RST));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
